// File: rtl/steg_pkg.sv
// Shared definitions for the LSB steganography embedder.
//   CT_W         ciphertext block width (AES block size)
//   SYNC_W       width of the optional per-block sync marker
//   SYNC_MARKER  marker value prefixed to each block when framing is enabled
//   state_t      embedder FSM states
//   pix_per_block() cover pixels consumed per block
package steg_pkg;

    localparam int unsigned       CT_W        = 128;
    localparam int unsigned       SYNC_W      = 16;
    localparam logic [SYNC_W-1:0] SYNC_MARKER = 16'hA55A;

    typedef enum logic {
        IDLE  = 1'b0,
        EMBED = 1'b1
    } state_t;

    function automatic int unsigned pix_per_block(input int unsigned bpp, input bit hdr_en);
        return (CT_W + (hdr_en ? SYNC_W : 0)) / bpp;
    endfunction

endpackage

// File: rtl/steg_bit_shifter.sv
// Parallel-load shift register plus pixel down-counter for the embedder.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       capture data_in and reload the counter with COUNT
//   shift      shift left by BPP (zero fill) and decrement the counter
//   data_in    block to embed (marker-prefixed when framing is enabled)
//   bits_out   top BPP bits of the register, next bits to embed
//   last       the counter is at 1: the next shift consumes the final bits
module steg_bit_shifter
    import steg_pkg::*;
#(
    parameter int unsigned W     = CT_W,
    parameter int unsigned BPP   = 1,
    parameter int unsigned COUNT = W / BPP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           shift,
    input  logic [W-1:0]   data_in,
    output logic [BPP-1:0] bits_out,
    output logic           last
);

    localparam int unsigned CNT_W = $clog2(COUNT + 1);

    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data_in;
            cnt   <= CNT_W'(COUNT);
        end else if (shift && (cnt != '0)) begin
            // Counter saturates at zero; a stray shift cannot wrap it.
            shreg <= {shreg[W-BPP-1:0], {BPP{1'b0}}};
            cnt   <= cnt - CNT_W'(1);
        end
    end

    assign bits_out = shreg[W-1 -: BPP];
    assign last     = (cnt == CNT_W'(1));

endmodule

// File: rtl/steg_lsb_embed.sv
// Hides each 128-bit CBC ciphertext block in the LSBs of a cover-pixel
// stream, BITS_PER_PIX bits per pixel, MSB first. Pixels pass through
// unmodified while no block is loaded.
// Optional feature: define STEG_SYNC_HDR_EN to prefix every block with the
// 16-bit marker 16'hA55A (144 bits embedded per block instead of 128).
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   ct_in/ct_valid/ct_ready         ciphertext block handshake
//   pix_in/pix_valid/pix_ready      cover pixel handshake
//   pix_out/pix_out_valid/_ready    stego pixel handshake (registered)
//   busy                            a block is loaded and not fully embedded
//   block_done                      pulse on the transfer of the last embedded pixel
module steg_lsb_embed #(
    parameter int unsigned PIX_W        = 8,
    parameter int unsigned BITS_PER_PIX = 1,
    parameter int unsigned CT_W         = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CT_W-1:0]  ct_in,
    input  logic             ct_valid,
    output logic             ct_ready,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] pix_out,
    output logic             pix_out_valid,
    input  logic             pix_out_ready,
    output logic             busy,
    output logic             block_done
);

    import steg_pkg::*;

`ifdef STEG_SYNC_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int unsigned NBITS       = CT_W + (HDR_EN ? SYNC_W : 0);
    localparam int unsigned PIX_PER_BLK = pix_per_block(BITS_PER_PIX, HDR_EN);

    if (!(BITS_PER_PIX == 1 || BITS_PER_PIX == 2 || BITS_PER_PIX == 4)) begin : g_bad_bpp
        $error("steg_lsb_embed: BITS_PER_PIX must be 1, 2 or 4");
    end
    if (CT_W != steg_pkg::CT_W) begin : g_bad_ct_w
        $error("steg_lsb_embed: CT_W is fixed to the AES block size");
    end

    state_t                  state, next_state;
    logic                    load, shift, last;
    logic [BITS_PER_PIX-1:0] bits_out;
    logic [NBITS-1:0]        load_data;
    logic                    pix_xfer;
    logic [PIX_W-1:0]        pix_next;

`ifdef STEG_SYNC_HDR_EN
    assign load_data = {SYNC_MARKER, ct_in};
`else
    assign load_data = ct_in;
`endif

    assign pix_ready = !pix_out_valid || pix_out_ready;
    assign pix_xfer  = pix_valid && pix_ready;

    steg_bit_shifter #(
        .W     (NBITS),
        .BPP   (BITS_PER_PIX),
        .COUNT (PIX_PER_BLK)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .data_in  (load_data),
        .bits_out (bits_out),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A pixel accepted in the same cycle as a block load is still in IDLE
    // and therefore passes through; embedding starts with the next pixel.
    always_comb begin
        next_state = state;
        ct_ready   = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        block_done = 1'b0;
        pix_next   = pix_in;
        case (state)
            IDLE: begin
                ct_ready = 1'b1;
                if (ct_valid) begin
                    load       = 1'b1;
                    next_state = EMBED;
                end
            end
            EMBED: begin
                busy = 1'b1;
                if (pix_xfer) begin
                    shift    = 1'b1;
                    pix_next = {pix_in[PIX_W-1:BITS_PER_PIX], bits_out};
                    if (last) begin
                        block_done = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
        end else if (pix_xfer) begin
            pix_out       <= pix_next;
            pix_out_valid <= 1'b1;
        end else if (pix_out_ready) begin
            pix_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_steg_lsb_embed.sv
module tb_steg_lsb_embed;

`ifdef STEG_SYNC_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int NB  = 128 + (HDR ? 16 : 0);
    localparam int NP2 = NB / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: BITS_PER_PIX = 1
    logic [127:0] ct_in;
    logic         ct_valid, ct_ready;
    logic [7:0]   pix_in, pix_out;
    logic         pix_valid, pix_ready, pix_out_valid, pix_out_ready, busy, block_done;

    // Instance B: BITS_PER_PIX = 2
    logic [127:0] b_ct_in;
    logic         b_ct_valid, b_ct_ready;
    logic [7:0]   b_pix_in, b_pix_out;
    logic         b_pix_valid, b_pix_ready, b_pix_out_valid, b_pix_out_ready, b_busy, b_block_done;

    steg_lsb_embed #(.PIX_W(8), .BITS_PER_PIX(1), .CT_W(128)) dut (
        .clk(clk), .rst(rst), .ct_in(ct_in), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
        .busy(busy), .block_done(block_done));

    steg_lsb_embed #(.PIX_W(8), .BITS_PER_PIX(2), .CT_W(128)) dut2 (
        .clk(clk), .rst(rst), .ct_in(b_ct_in), .ct_valid(b_ct_valid), .ct_ready(b_ct_ready),
        .pix_in(b_pix_in), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
        .pix_out(b_pix_out), .pix_out_valid(b_pix_out_valid), .pix_out_ready(b_pix_out_ready),
        .busy(b_busy), .block_done(b_block_done));

    int checks   = 0;
    int failures = 0;

    // Reference model for instance A: a queue of bits still to be hidden,
    // plus the expected output register.
    logic       mbits[$];
    logic       bbits[$];
    logic [7:0] m_out;
    logic       m_out_valid;
    logic [3:0] exp_comb, obs_comb;   // {pix_ready, ct_ready, busy, block_done}
    int         done_seen;

    task automatic push_block(input logic [127:0] ct, input int which);
        logic [15:0] marker;
        marker = 16'hA55A;
        if (HDR) begin
            for (int i = 15; i >= 0; i--) begin
                if (which == 0) mbits.push_back(marker[i]);
                else            bbits.push_back(marker[i]);
            end
        end
        for (int i = 127; i >= 0; i--) begin
            if (which == 0) mbits.push_back(ct[i]);
            else            bbits.push_back(ct[i]);
        end
    endtask

    task automatic model_reset();
        mbits.delete();
        m_out       = 8'h00;
        m_out_valid = 1'b0;
    endtask

    // Advance instance A one cycle: sample combinational outputs before the
    // edge, update the model with this cycle's transfers, land at edge+1.
    task automatic tick();
        logic       px, cx;
        logic [7:0] o;
        @(negedge clk);
        exp_comb = {(!m_out_valid || pix_out_ready), (mbits.size() == 0), (mbits.size() != 0), 1'b0};
        px = pix_valid && exp_comb[3];
        cx = ct_valid && exp_comb[2];
        if (px && mbits.size() == 1) exp_comb[0] = 1'b1;
        obs_comb = {pix_ready, ct_ready, busy, block_done};
        if (px) begin
            o = pix_in;
            if (mbits.size() != 0) o[0] = mbits.pop_front();
            m_out       = o;
            m_out_valid = 1'b1;
        end else if (pix_out_ready) begin
            m_out_valid = 1'b0;
        end
        if (cx) push_block(ct_in, 0);
        if (exp_comb[0]) done_seen++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({pix_ready, ct_ready, busy, block_done, pix_out_valid, pix_out} !== {5'b11000, 8'h00}) begin
            failures++;
            $display("FAIL reset got=%b exp=%b",
                     {pix_ready, ct_ready, busy, block_done, pix_out_valid, pix_out}, {5'b11000, 8'h00});
        end
    endtask

    task automatic test_passthrough();
        logic [7:0] pats [2];
        pats[0] = 8'h3C;
        pats[1] = 8'hFF;
        pix_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pix_in    = pats[k];
            pix_valid = 1'b1;
            tick();
            checks++;
            if (obs_comb !== exp_comb) begin
                failures++;
                $display("FAIL pt_comb k=%0d got=%b exp=%b", k, obs_comb, exp_comb);
            end
            checks++;
            if ({pix_out_valid, pix_out, busy} !== {1'b1, pats[k], 1'b0}) begin
                failures++;
                $display("FAIL pt_out k=%0d got=%h exp=%h", k, {pix_out_valid, pix_out, busy}, {1'b1, pats[k], 1'b0});
            end
        end
        pix_valid = 1'b0;
        tick();
        checks++;
        if ({pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
            failures++;
            $display("FAIL pt_drain got=%h exp=%h", {pix_out_valid, pix_out}, {m_out_valid, m_out});
        end
    endtask

    task automatic test_embed_directed();
        logic [7:0] exp_c;
        ct_in         = 128'hA0000000_00000000_00000000_00000001;
        ct_valid      = 1'b1;
        pix_valid     = 1'b0;
        pix_out_ready = 1'b1;
        tick();
        checks++;
        if (obs_comb !== exp_comb) begin
            failures++;
            $display("FAIL emb_load got=%b exp=%b", obs_comb, exp_comb);
        end
        ct_valid  = 1'b0;
        done_seen = 0;
        for (int k = 0; k <= NB; k++) begin
            pix_in    = 8'hFF;
            pix_valid = 1'b1;
            tick();
            checks++;
            if (obs_comb !== exp_comb) begin
                failures++;
                $display("FAIL emb_comb k=%0d got=%b exp=%b", k, obs_comb, exp_comb);
            end
            checks++;
            if ({pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
                failures++;
                $display("FAIL emb_out k=%0d got=%h exp=%h", k, {pix_out_valid, pix_out}, {m_out_valid, m_out});
            end
`ifndef STEG_SYNC_HDR_EN
            exp_c = (k == 0 || k == 2 || k >= 127) ? 8'hFF : 8'hFE;
            checks++;
            if (pix_out !== exp_c) begin
                failures++;
                $display("FAIL emb_const k=%0d got=%h exp=%h", k, pix_out, exp_c);
            end
`endif
            if (k == NB - 1) begin
                checks++;
                if (obs_comb[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL emb_done_pos got=%b exp=1", obs_comb[0]);
                end
            end
        end
        checks++;
        if (done_seen != 1 || obs_comb[0] !== 1'b0) begin
            failures++;
            $display("FAIL emb_done_count got=%0d exp=1", done_seen);
        end
        pix_valid = 1'b0;
        tick();
        checks++;
        if (obs_comb !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL emb_after got=%b exp=1100", obs_comb);
        end
    endtask

`ifdef STEG_SYNC_HDR_EN
    task automatic test_hdr();
        logic [15:0] marker;
        marker        = 16'hA55A;
        ct_in         = rand128();
        ct_valid      = 1'b1;
        pix_valid     = 1'b0;
        pix_out_ready = 1'b1;
        tick();
        ct_valid = 1'b0;
        for (int k = 0; k < 144; k++) begin
            pix_in    = 8'h00;
            pix_valid = 1'b1;
            tick();
            if (k < 16) begin
                checks++;
                if (pix_out !== {7'd0, marker[15-k]}) begin
                    failures++;
                    $display("FAIL hdr_bit k=%0d got=%h exp=%h", k, pix_out, {7'd0, marker[15-k]});
                end
            end
            checks++;
            if (obs_comb !== exp_comb || {pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
                failures++;
                $display("FAIL hdr_out k=%0d got=%b_%h exp=%b_%h", k, obs_comb, pix_out, exp_comb, m_out);
            end
            if (k == 143) begin
                checks++;
                if (obs_comb[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL hdr_done got=%b exp=1", obs_comb[0]);
                end
            end
        end
        pix_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_backpressure();
        ct_in         = rand128();
        ct_valid      = 1'b1;
        pix_valid     = 1'b0;
        pix_out_ready = 1'b1;
        tick();
        ct_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pix_in    = 8'($urandom);
            pix_valid = 1'b1;
            tick();
            checks++;
            if (obs_comb !== exp_comb || {pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
                failures++;
                $display("FAIL bp_pre k=%0d got=%b_%h exp=%b_%h", k, obs_comb, pix_out, exp_comb, m_out);
            end
        end
        pix_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pix_in    = 8'($urandom);
            pix_valid = 1'b1;
            tick();
            checks++;
            if (obs_comb !== exp_comb || obs_comb[3] !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall_comb k=%0d got=%b exp=%b", k, obs_comb, exp_comb);
            end
            checks++;
            if ({pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
                failures++;
                $display("FAIL bp_stall_out k=%0d got=%h exp=%h", k, {pix_out_valid, pix_out}, {m_out_valid, m_out});
            end
        end
        for (int k = 0; k < 400 && mbits.size() != 0; k++) begin
            pix_in        = 8'($urandom);
            pix_valid     = ($urandom_range(3) != 0);
            pix_out_ready = ($urandom_range(3) != 0);
            tick();
            checks++;
            if (obs_comb !== exp_comb || {pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
                failures++;
                $display("FAIL bp_resume k=%0d got=%b_%h exp=%b_%h", k, obs_comb, pix_out, exp_comb, m_out);
            end
        end
        pix_valid     = 1'b0;
        pix_out_ready = 1'b1;
        tick();
        checks++;
        if (obs_comb[2] !== 1'b1) begin
            failures++;
            $display("FAIL bp_end_ct_ready got=%b exp=1", obs_comb[2]);
        end
    endtask

    task automatic test_reset_mid();
        ct_in         = rand128();
        ct_valid      = 1'b1;
        pix_valid     = 1'b0;
        pix_out_ready = 1'b1;
        tick();
        ct_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            pix_in    = 8'($urandom);
            pix_valid = 1'b1;
            tick();
            checks++;
            if (obs_comb !== exp_comb || {pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
                failures++;
                $display("FAIL rm_pre k=%0d got=%b_%h exp=%b_%h", k, obs_comb, pix_out, exp_comb, m_out);
            end
        end
        pix_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ct_ready, busy, block_done, pix_out_valid, pix_out} !== {4'b1000, 8'h00}) begin
            failures++;
            $display("FAIL rm_async got=%b exp=%b", {ct_ready, busy, block_done, pix_out_valid, pix_out}, {4'b1000, 8'h00});
        end
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        ct_in    = rand128();
        ct_valid = 1'b1;
        tick();
        ct_valid = 1'b0;
        for (int k = 0; k <= NB; k++) begin
            pix_in    = 8'($urandom);
            pix_valid = 1'b1;
            tick();
            checks++;
            if (obs_comb !== exp_comb || {pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
                failures++;
                $display("FAIL rm_post k=%0d got=%b_%h exp=%b_%h", k, obs_comb, pix_out, exp_comb, m_out);
            end
        end
        pix_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            ct_in         = rand128();
            ct_valid      = ($urandom_range(3) == 0);
            pix_in        = 8'($urandom);
            pix_valid     = ($urandom_range(3) != 0);
            pix_out_ready = ($urandom_range(3) != 0);
            tick();
            checks++;
            if (obs_comb !== exp_comb || {pix_out_valid, pix_out} !== {m_out_valid, m_out}) begin
                failures++;
                $display("FAIL rnd k=%0d got=%b_%h exp=%b_%h", k, obs_comb, pix_out, exp_comb, m_out);
            end
        end
        ct_valid  = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic test_bpp2();
        logic [7:0] table2 [4];
        logic [7:0] px, exp_o;
        logic       hi, lo;
        table2[0] = 8'h03; table2[1] = 8'h00; table2[2] = 8'h01; table2[3] = 8'h02;
        bbits.delete();
        b_ct_in         = {8'hC6, 120'(rand128())};
        push_block(b_ct_in, 1);
        b_pix_out_ready = 1'b1;
        b_ct_valid      = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ct_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2_ct_ready got=%b exp=1", b_ct_ready);
        end
        @(posedge clk);
        #1;
        b_ct_valid  = 1'b0;
        b_pix_valid = 1'b1;
        for (int k = 0; k < NP2; k++) begin
            px       = (k < 4) ? 8'h00 : 8'($urandom);
            b_pix_in = px;
            @(negedge clk);
            checks++;
            if (b_block_done !== (k == NP2 - 1)) begin
                failures++;
                $display("FAIL b2_done k=%0d got=%b exp=%b", k, b_block_done, (k == NP2 - 1));
            end
            @(posedge clk);
            #1;
            hi    = bbits.pop_front();
            lo    = bbits.pop_front();
            exp_o = {px[7:2], hi, lo};
            checks++;
            if ({b_pix_out_valid, b_pix_out} !== {1'b1, exp_o}) begin
                failures++;
                $display("FAIL b2_out k=%0d got=%h exp=%h", k, {b_pix_out_valid, b_pix_out}, {1'b1, exp_o});
            end
`ifndef STEG_SYNC_HDR_EN
            if (k < 4) begin
                checks++;
                if (b_pix_out !== table2[k]) begin
                    failures++;
                    $display("FAIL b2_const k=%0d got=%h exp=%h", k, b_pix_out, table2[k]);
                end
            end
`endif
        end
        b_pix_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_ct_ready, b_busy} !== 2'b10) begin
            failures++;
            $display("FAIL b2_idle got=%b exp=10", {b_ct_ready, b_busy});
        end
    endtask

    initial begin
        rst             = 1'b1;
        ct_in           = '0; ct_valid   = 1'b0; pix_in   = '0; pix_valid   = 1'b0; pix_out_ready   = 1'b0;
        b_ct_in         = '0; b_ct_valid = 1'b0; b_pix_in = '0; b_pix_valid = 1'b0; b_pix_out_ready = 1'b0;
        done_seen       = 0;
        model_reset();
        test_reset();
        test_passthrough();
        test_embed_directed();
`ifdef STEG_SYNC_HDR_EN
        test_hdr();
`endif
        test_backpressure();
        test_reset_mid();
        test_random();
        test_bpp2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
